dmem_resp_320: RTL and testbench

Data-memory responder for the CPU's load/store port. Accepts one request at a time over a valid/ready handshake and executes word and byte stores, and word, signed-byte and unsigned-byte loads. Storage is a synchronous-read word RAM. Byte stores run as a two-phase read-modify-write. It sits between the CPU's `wren`/`sb`/`lb`/`lbu`/`dataAddress`/`writeData` outputs and its `data` input, for the multi-cycle CPU variant.

---
 rtl/dmem_pkg_320.sv | 45 ++++
 rtl/dmem_ram_320.sv | 29 ++
 rtl/dmem_resp_320.sv | 175 +++++++++++++++++
 tb/tb_dmem_resp_320.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg_320.sv
// dmem_pkg_320: shared types and constants for the dmem_resp_320 data-memory responder.
//   state_e    - responder FSM states
//   req_type_e - decoded request kind
//   req_t      - captured request fields (type, byte lane, byte store data)
package dmem_pkg_320;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RMW  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RT_SW  = 3'd0,
    RT_SB  = 3'd1,
    RT_LW  = 3'd2,
    RT_LB  = 3'd3,
    RT_LBU = 3'd4
  } req_type_e;

  localparam logic [LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [LANE_W-1:0] LANE3 = 2'd3;

  typedef struct packed {
    req_type_e          typ;
    logic [LANE_W-1:0]  lane;
    logic [BYTE_W-1:0]  bdata;
  } req_t;

  // Stores: sb picks byte/word. Loads: lbu has priority over lb.
  function automatic req_type_e decode_req(input logic wren, input logic sb,
                                           input logic lb, input logic lbu);
    if (wren)     return sb ? RT_SB : RT_SW;
    else if (lbu) return RT_LBU;
    else if (lb)  return RT_LB;
    else          return RT_LW;
  endfunction

endpackage

// File: rtl/dmem_ram_320.sv
// dmem_ram_320: single-port 2^ADDR_W x 32 word RAM, synchronous read.
//   clk   - clock
//   we    - write enable
//   re    - read enable; rdata updates on the read edge, holds otherwise
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (old contents on read-during-write)
module dmem_ram_320 #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Storage array and read register; nonblocking read gives old data on collision.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp_320.sv
// dmem_resp_320: data-memory responder for the CPU load/store port.
// One request at a time over req_valid/req_ready; word stores complete on the
// accept edge, loads and byte stores (read-modify-write) take one extra cycle.
// Optional: define DMEM_ALIGN_CHECK_EN to flag misaligned word accesses via err.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake (ready only in IDLE)
//   wren, sb, lb, lbu        - request kind
//   dataAddress, writeData   - byte address and store data
//   rsp_valid                - one-cycle completion pulse
//   data                     - load result, held until the next load response
//   err                      - qualifies rsp_valid (misaligned word access)
module dmem_resp_320
  import dmem_pkg_320::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        wren,
  input  logic        sb,
  input  logic        lb,
  input  logic        lbu,
  input  logic [31:0] dataAddress,
  input  logic [31:0] writeData,
  output logic        rsp_valid,
  output logic [31:0] data,
  output logic        err
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [ADDR_W-1:0] idx_q;

  req_type_e         in_typ;
  logic [ADDR_W-1:0] in_idx;
  logic              accept;
  logic              misaligned_c;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [7:0]        rd_byte;
  logic [31:0]       load_fmt, merged;
  logic              rsp_d, err_d;
  logic [31:0]       data_d;

  // Address bits above the RAM size wrap and are deliberately dropped.
  logic unused_addr_c;
  assign unused_addr_c = ^dataAddress[31:ADDR_W+2];

  assign in_typ    = decode_req(wren, sb, lb, lbu);
  assign in_idx    = dataAddress[ADDR_W+1:2];
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & (state_q == ST_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned_c = ((in_typ == RT_SW) || (in_typ == RT_LW)) &&
                        (dataAddress[1:0] != 2'd0);
`else
  assign misaligned_c = 1'b0;
`endif

  dmem_ram_320 #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !misaligned_c) begin
          case (in_typ)
            RT_SB:                state_d = ST_RMW;
            RT_LW, RT_LB, RT_LBU: state_d = ST_LOAD;
            default:              state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RMW:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for byte stores.
  always_comb begin
    rd_byte = ram_rdata[7:0];
    merged  = ram_rdata;
    case (req_q.lane)
      LANE0: begin rd_byte = ram_rdata[7:0];   merged[7:0]   = req_q.bdata; end
      LANE1: begin rd_byte = ram_rdata[15:8];  merged[15:8]  = req_q.bdata; end
      LANE2: begin rd_byte = ram_rdata[23:16]; merged[23:16] = req_q.bdata; end
      LANE3: begin rd_byte = ram_rdata[31:24]; merged[31:24] = req_q.bdata; end
      default: ;
    endcase
    case (req_q.typ)
      RT_LB:   load_fmt = {{24{rd_byte[7]}}, rd_byte};
      RT_LBU:  load_fmt = {24'd0, rd_byte};
      default: load_fmt = ram_rdata;
    endcase
  end

  // Output / RAM control logic.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = in_idx;
    ram_wdata = writeData;
    rsp_d     = 1'b0;
    err_d     = 1'b0;
    data_d    = data;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned_c) begin
            rsp_d = 1'b1;
            err_d = 1'b1;
          end else if (in_typ == RT_SW) begin
            ram_we = 1'b1;
            rsp_d  = 1'b1;
          end else begin
            ram_re = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        rsp_d  = 1'b1;
        data_d = load_fmt;
      end
      ST_RMW: begin
        ram_addr  = idx_q;
        ram_wdata = merged;
        ram_we    = 1'b1;
        rsp_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      data      <= 32'd0;
      req_q     <= '0;
      idx_q     <= '0;
    end else begin
      rsp_valid <= rsp_d;
      err       <= err_d;
      data      <= data_d;
      if (accept) begin
        req_q <= '{typ: in_typ, lane: dataAddress[1:0], bdata: writeData[7:0]};
        idx_q <= in_idx;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp_320.sv
// tb_dmem_resp_320: scoreboard bench for dmem_resp_320 (directed + random traffic).
module tb_dmem_resp_320;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        wren = 1'b0, sb = 1'b0, lb = 1'b0, lbu = 1'b0;
  logic [31:0] dataAddress = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic        rsp_valid;
  logic [31:0] data;
  logic        err;

  dmem_resp_320 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .wren(wren), .sb(sb), .lb(lb), .lbu(lbu),
    .dataAddress(dataAddress), .writeData(writeData),
    .rsp_valid(rsp_valid), .data(data), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          exp_cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] last_load = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory semantics, one response per request.
  task automatic model_req(input logic w, input logic s, input logic l, input logic lu,
                           input logic [31:0] addr, input logic [31:0] wd, input int acc);
    int          idx, lane, sh;
    bit          mis;
    logic [31:0] b, r;
    exp_t        e;
    idx  = int'((addr / 4) % DEPTH);
    lane = int'(addr % 4);
    sh   = 8 * lane;
    mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (w ? !s : !(l || lu)) && (lane != 0);
`endif
    e.err = 1'b0;
    if (mis) begin
      e.exp_cyc = acc; e.data = last_load; e.err = 1'b1;
    end else if (w && !s) begin
      mem[idx]  = wd;
      e.exp_cyc = acc; e.data = last_load;
    end else if (w) begin
      b         = wd % 256;
      mem[idx]  = (mem[idx] & ~(32'hFF << sh)) | (b << sh);
      e.exp_cyc = acc + 1; e.data = last_load;
    end else begin
      b = (mem[idx] >> sh) % 256;
      if (lu)     r = b;
      else if (l) r = (b >= 128) ? (32'hFFFF_FF00 | b) : b;
      else        r = mem[idx];
      last_load = r;
      e.exp_cyc = acc + 1; e.data = r;
    end
    q.push_back(e);
  endtask

  // Drive one request, wait (bounded) for acceptance, then record expectation.
  task automatic do_req(input logic w, input logic s, input logic l, input logic lu,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
        return;
      end
      @(negedge clk);
    end
    wren = w; sb = s; lb = l; lbu = lu; dataAddress = addr; writeData = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_req(w, s, l, lu, addr, wd, cyc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check32("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Monitor: every response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check32("rsp_cycle", 32'(cyc), 32'(e.exp_cyc));
        check32("rsp_data", data, e.data);
        check32("rsp_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          t;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("reset_data", data, 32'd0);
    check32("reset_err", {31'd0, err}, 32'd0);

    // Known RAM contents via back-to-back word stores.
    for (int i = 0; i < int'(DEPTH); i++) do_req(1, 0, 0, 0, 32'(i * 4), 32'd0);
    drain();

    do_req(1, 0, 0, 0, 32'h10, 32'hDEAD_BEEF);
    do_req(0, 0, 0, 0, 32'h10, 32'd0);
    do_req(1, 0, 0, 0, 32'h10, 32'h1122_3344);
    do_req(1, 1, 0, 0, 32'h11, 32'h0000_0080);
    do_req(0, 0, 0, 0, 32'h10, 32'd0);
    do_req(0, 0, 1, 0, 32'h11, 32'd0);
    do_req(0, 0, 0, 1, 32'h11, 32'd0);
    do_req(1, 0, 0, 0, 32'h10, 32'hF000_0000);
    do_req(0, 0, 1, 1, 32'h13, 32'd0);
    do_req(1, 0, 0, 0, 32'h1000, 32'h1);
    do_req(0, 0, 0, 0, 32'h0, 32'd0);
    do_req(1, 0, 0, 0, 32'h20, 32'h0);
    drain();

    // Reset during the RMW cycle of a byte store: no write-back, no response.
    @(negedge clk);
    wren = 1'b1; sb = 1'b1; lb = 1'b0; lbu = 1'b0;
    dataAddress = 32'h20; writeData = 32'h0000_00AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_load = 32'd0;
    @(negedge clk);
    check32("rmw_reset_req_ready", {31'd0, req_ready}, 32'd1);
    check32("rmw_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rmw_reset_data", data, 32'd0);
    check32("rmw_reset_err", {31'd0, err}, 32'd0);
    do_req(0, 0, 0, 0, 32'h20, 32'd0);

    // Misaligned word accesses (err with the check enabled, lane ignored otherwise).
    do_req(1, 0, 0, 0, 32'h22, 32'hCAFE_F00D);
    do_req(0, 0, 0, 0, 32'h20, 32'd0);
    do_req(0, 0, 0, 0, 32'h23, 32'd0);
    do_req(1, 1, 0, 0, 32'h23, 32'h0000_0055);
    do_req(0, 0, 0, 0, 32'h20, 32'd0);
    drain();

    // Random traffic over a small window so accesses collide often.
    for (int i = 0; i < 400; i++) begin
      t = int'($urandom_range(0, 4));
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      d = $urandom;
      case (t)
        0: do_req(1, 0, 1'($urandom), 1'($urandom), a, d);
        1: do_req(1, 1, 1'($urandom), 1'($urandom), a, d);
        2: do_req(0, 1'($urandom), 0, 0, a, d);
        3: do_req(0, 1'($urandom), 1, 0, a, d);
        default: do_req(0, 1'($urandom), 1'($urandom), 1, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
